// File: rtl/dcache_2way_param.sv
// Two-way set-associative, write-back / write-allocate L1 data cache with per-set
// LRU replacement, register-array storage and saturating hit/miss counters.
module dcache_2way_param #(
  parameter int ADDR_W     = 32,
  parameter int LINE_BYTES = 32,
  parameter int SETS       = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [ADDR_W-1:0]       p1_addr_i,
  input  logic [31:0]             p1_data_i,
  input  logic                    p1_MemRead_i,
  input  logic                    p1_MemWrite_i,
  output logic [31:0]             p1_data_o,
  output logic                    p1_stall_o,
  output logic [ADDR_W-1:0]       mem_addr_o,
  output logic [8*LINE_BYTES-1:0] mem_data_o,
  output logic                    mem_enable_o,
  output logic                    mem_write_o,
  input  logic [8*LINE_BYTES-1:0] mem_data_i,
  input  logic                    mem_ack_i,
  output logic [31:0]             hit_cnt_o,
  output logic [31:0]             miss_cnt_o
);

  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WSEL_W = OFF_W - 2;

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_MISS        = 3'd1;
  localparam logic [2:0] ST_WRITEBACK   = 3'd2;
  localparam logic [2:0] ST_REFILL      = 3'd3;
  localparam logic [2:0] ST_REFILL_DONE = 3'd4;

  logic [2:0]        state_q;
  logic [TAG_W-1:0]  tag_q  [2][SETS];
  logic [LINE_W-1:0] data_q [2][SETS];
  logic [SETS-1:0]   valid_q [2];
  logic [SETS-1:0]   dirty_q [2];
  logic [SETS-1:0]   lru_q;
  logic              victim_q;
  logic [TAG_W-1:0]  miss_tag_q;
  logic [IDX_W-1:0]  miss_idx_q;

  logic              req;
  logic              lookup_en;
  logic              hit0;
  logic              hit1;
  logic              hit;
  logic              hit_way;
  logic              vic_way;
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [WSEL_W-1:0] req_wsel;
  logic [WSEL_W+4:0] word_lsb;
  logic [LINE_W-1:0] hit_line;
  logic [ADDR_W-1:0] refill_addr;
  logic              addr_unused;

  assign req         = p1_MemRead_i | p1_MemWrite_i;
  assign req_tag     = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign req_idx     = p1_addr_i[OFF_W +: IDX_W];
  assign req_wsel    = p1_addr_i[2 +: WSEL_W];
  assign word_lsb    = {req_wsel, 5'd0};
  assign addr_unused = ^p1_addr_i[1:0];
  assign refill_addr = {miss_tag_q, miss_idx_q, {OFF_W{1'b0}}};

  // Lookups only count while no memory transaction owns the arrays; REFILL_DONE
  // lets the waiting access complete as soon as the new line is installed.
  assign lookup_en = (state_q == ST_IDLE) || (state_q == ST_REFILL_DONE);
  assign hit0 = lookup_en & req & valid_q[0][req_idx] & (tag_q[0][req_idx] == req_tag);
  assign hit1 = lookup_en & req & valid_q[1][req_idx] & (tag_q[1][req_idx] == req_tag);
  assign hit     = hit0 | hit1;
  assign hit_way = hit1;

  assign hit_line   = hit1 ? data_q[1][req_idx] : data_q[0][req_idx];
  assign p1_data_o  = (hit && p1_MemRead_i) ? hit_line[word_lsb +: 32] : 32'd0;
  assign p1_stall_o = req & ~hit;

  always_comb begin
    vic_way = lru_q[miss_idx_q];
    if (!valid_q[0][miss_idx_q]) begin
      vic_way = 1'b0;
    end else if (!valid_q[1][miss_idx_q]) begin
      vic_way = 1'b1;
    end
  end

  // Line data and tags are qualified by the valid bits, so they need no reset.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_REFILL && mem_ack_i) begin
      data_q[victim_q][miss_idx_q] <= mem_data_i;
      tag_q[victim_q][miss_idx_q]  <= miss_tag_q;
    end else if (hit && p1_MemWrite_i) begin
      data_q[hit_way][req_idx][word_lsb +: 32] <= p1_data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= ST_IDLE;
      valid_q[0]   <= '0;
      valid_q[1]   <= '0;
      dirty_q[0]   <= '0;
      dirty_q[1]   <= '0;
      lru_q        <= '0;
      victim_q     <= 1'b0;
      miss_tag_q   <= '0;
      miss_idx_q   <= '0;
      hit_cnt_o    <= 32'd0;
      miss_cnt_o   <= 32'd0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      if (hit) begin
        lru_q[req_idx] <= ~hit_way;
        if (hit_cnt_o != 32'hFFFF_FFFF) begin
          hit_cnt_o <= hit_cnt_o + 32'd1;
        end
        if (p1_MemWrite_i) begin
          dirty_q[hit_way][req_idx] <= 1'b1;
        end
      end

      case (state_q)
        ST_IDLE: begin
          if (req && !hit) begin
            if (miss_cnt_o != 32'hFFFF_FFFF) begin
              miss_cnt_o <= miss_cnt_o + 32'd1;
            end
            miss_tag_q <= req_tag;
            miss_idx_q <= req_idx;
            state_q    <= ST_MISS;
          end
        end

        ST_MISS: begin
          victim_q     <= vic_way;
          mem_enable_o <= 1'b1;
          if (valid_q[vic_way][miss_idx_q] && dirty_q[vic_way][miss_idx_q]) begin
            mem_write_o <= 1'b1;
            mem_addr_o  <= {tag_q[vic_way][miss_idx_q], miss_idx_q, {OFF_W{1'b0}}};
            mem_data_o  <= data_q[vic_way][miss_idx_q];
            state_q     <= ST_WRITEBACK;
          end else begin
            mem_write_o <= 1'b0;
            mem_addr_o  <= refill_addr;
            state_q     <= ST_REFILL;
          end
        end

        ST_WRITEBACK: begin
          if (mem_ack_i) begin
            mem_write_o <= 1'b0;
            mem_addr_o  <= refill_addr;
            state_q     <= ST_REFILL;
          end
        end

        ST_REFILL: begin
          if (mem_ack_i) begin
            valid_q[victim_q][miss_idx_q] <= 1'b1;
            dirty_q[victim_q][miss_idx_q] <= 1'b0;
            mem_enable_o                  <= 1'b0;
            state_q                       <= ST_REFILL_DONE;
          end
        end

        ST_REFILL_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_2way_param.sv
// Self-checking bench for dcache_2way_param: a line-wide memory responder plus a
// recency-list cache model and a flat word image that define every expectation.
module tb_dcache_2way_param;

  logic         clk_i;
  logic         rst_i;
  logic [31:0]  p1_addr_i;
  logic [31:0]  p1_data_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;

  dcache_2way_param dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .p1_addr_i     (p1_addr_i),
    .p1_data_i     (p1_data_i),
    .p1_MemRead_i  (p1_MemRead_i),
    .p1_MemWrite_i (p1_MemWrite_i),
    .p1_data_o     (p1_data_o),
    .p1_stall_o    (p1_stall_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_enable_o  (mem_enable_o),
    .mem_write_o   (mem_write_o),
    .mem_data_i    (mem_data_i),
    .mem_ack_i     (mem_ack_i),
    .hit_cnt_o     (hit_cnt_o),
    .miss_cnt_o    (miss_cnt_o)
  );

  int checks = 0;
  int errors = 0;

  // Backing memory (16 KB of lines) and the architectural word image loads must return.
  logic [255:0] mem_lines [512];
  logic [31:0]  arch_words [4096];

  int unsigned mdl_tag   [32][2];
  bit          mdl_dirty [32][2];
  int          mdl_cnt   [32];
  int          mdl_hits;
  int          mdl_misses;

  int           ack_delay = 1;
  int           wait_cnt = 0;
  int           stab_err = 0;
  logic [31:0]  cap_addr;
  logic         cap_write;
  logic [255:0] cap_data;
  bit           txn_wr   [$];
  logic [31:0]  txn_addr [$];
  logic [255:0] txn_data [$];

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Memory acknowledges ack_delay cycles after first seeing a request, logs every
  // transaction and flags any request output that moves before its ack.
  always @(negedge clk_i) begin
    mem_ack_i = 1'b0;
    if (mem_enable_o !== 1'b1) begin
      wait_cnt = 0;
    end else begin
      if (wait_cnt == 0) begin
        cap_addr  = mem_addr_o;
        cap_write = mem_write_o;
        cap_data  = mem_data_o;
      end else if (mem_addr_o !== cap_addr || mem_write_o !== cap_write || mem_data_o !== cap_data) begin
        stab_err++;
      end
      wait_cnt++;
      if (wait_cnt > ack_delay) begin
        mem_ack_i = 1'b1;
        txn_wr.push_back(mem_write_o);
        txn_addr.push_back(mem_addr_o);
        if (mem_write_o) begin
          mem_lines[mem_addr_o[13:5]] = mem_data_o;
          txn_data.push_back(mem_data_o);
        end else begin
          mem_data_i = mem_lines[mem_addr_o[13:5]];
          txn_data.push_back(mem_data_i);
        end
        wait_cnt = 0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [255:0] arch_line(input int line);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = arch_words[line*8 + k];
    return l;
  endfunction

  task automatic model_reset();
    for (int s = 0; s < 32; s++) mdl_cnt[s] = 0;
    mdl_hits   = 0;
    mdl_misses = 0;
    for (int i = 0; i < 4096; i++) arch_words[i] = mem_lines[i / 8][(i % 8) * 32 +: 32];
  endtask

  // One CPU access: predict it from the model, drive it, then check stall length,
  // load data, memory traffic and counters. Called and returns on a falling edge.
  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wdata);
    int           idx;
    int           pos;
    int           exp_stall;
    int           exp_n;
    int           stall_cycles;
    int unsigned  tg;
    int unsigned  tmp_tag;
    bit           tmp_dirty;
    bit           wb;
    logic [31:0]  wb_addr;
    logic [31:0]  fill_addr;
    logic [255:0] wb_line;

    idx       = int'(addr[9:5]);
    tg        = addr >> 10;
    fill_addr = addr & 32'hFFFF_FFE0;
    pos       = -1;
    wb        = 1'b0;
    wb_addr   = '0;
    wb_line   = '0;
    for (int i = 0; i < mdl_cnt[idx]; i++) if (mdl_tag[idx][i] == tg) pos = i;

    if (pos >= 0) begin
      exp_stall = 0;
      exp_n     = 0;
      if (pos == 1) begin
        tmp_tag            = mdl_tag[idx][0];
        tmp_dirty          = mdl_dirty[idx][0];
        mdl_tag[idx][0]    = mdl_tag[idx][1];
        mdl_dirty[idx][0]  = mdl_dirty[idx][1];
        mdl_tag[idx][1]    = tmp_tag;
        mdl_dirty[idx][1]  = tmp_dirty;
      end
    end else begin
      mdl_misses++;
      if (mdl_cnt[idx] == 2 && mdl_dirty[idx][1]) begin
        wb      = 1'b1;
        wb_addr = (mdl_tag[idx][1] << 10) | (idx << 5);
        wb_line = arch_line(int'(wb_addr[13:5]));
      end
      mdl_tag[idx][1]   = mdl_tag[idx][0];
      mdl_dirty[idx][1] = mdl_dirty[idx][0];
      mdl_tag[idx][0]   = tg;
      mdl_dirty[idx][0] = 1'b0;
      if (mdl_cnt[idx] < 2) mdl_cnt[idx]++;
      exp_stall = wb ? 2 * ack_delay + 4 : ack_delay + 3;
      exp_n     = wb ? 2 : 1;
    end
    mdl_hits++;
    if (wr) mdl_dirty[idx][0] = 1'b1;

    txn_wr.delete();
    txn_addr.delete();
    txn_data.delete();
    p1_addr_i     = addr;
    p1_data_i     = wdata;
    p1_MemRead_i  = !wr;
    p1_MemWrite_i = wr;
    #1;
    stall_cycles = 0;
    while (p1_stall_o === 1'b1 && stall_cycles < 300) begin
      @(negedge clk_i);
      #1;
      stall_cycles++;
    end
    checkOutput("stall_cycles", stall_cycles, exp_stall);
    if (!wr) checkOutput("load_data", p1_data_o, arch_words[addr[13:2]]);
    @(negedge clk_i);
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
    if (wr) arch_words[addr[13:2]] = wdata;

    checkOutput("txn_count", txn_wr.size(), exp_n);
    if (exp_n > 0 && txn_wr.size() == exp_n) begin
      if (wb) begin
        checkOutput("wb_write", txn_wr[0], 1);
        checkOutput("wb_addr", txn_addr[0], wb_addr);
        checkOutput("wb_data", txn_data[0], wb_line);
      end
      checkOutput("fill_write", txn_wr[exp_n-1], 0);
      checkOutput("fill_addr", txn_addr[exp_n-1], fill_addr);
    end
    checkOutput("hit_cnt", hit_cnt_o, mdl_hits);
    checkOutput("miss_cnt", miss_cnt_o, mdl_misses);
  endtask

  initial begin
    int          n;
    logic [31:0] a;

    rst_i         = 1'b0;
    p1_addr_i     = '0;
    p1_data_i     = '0;
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
    mem_data_i    = '0;
    mem_ack_i     = 1'b0;
    for (int l = 0; l < 512; l++)
      for (int k = 0; k < 8; k++) mem_lines[l][k*32 +: 32] = $urandom;
    mem_lines[0][63:32] = 32'h1111_1111;
    model_reset();

    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    checkOutput("rst_mem_enable", mem_enable_o, 0);
    checkOutput("rst_mem_write", mem_write_o, 0);
    checkOutput("rst_mem_addr", mem_addr_o, 0);
    checkOutput("rst_hit_cnt", hit_cnt_o, 0);
    checkOutput("rst_miss_cnt", miss_cnt_o, 0);
    checkOutput("rst_stall", p1_stall_o, 0);
    checkOutput("rst_data", p1_data_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);

    $display("[TB] cold read, write hit, LRU and dirty-victim sequence");
    ack_delay = 1;
    applyStimulus(1'b0, 32'h0000_0004, 32'h0);
    checkOutput("t1_load_const", arch_words[1], 32'h1111_1111);
    applyStimulus(1'b1, 32'h0000_0008, 32'hDEAD_BEEF);
    applyStimulus(1'b0, 32'h0000_0008, 32'h0);
    applyStimulus(1'b0, 32'h0000_0400, 32'h0);
    applyStimulus(1'b0, 32'h0000_0000, 32'h0);
    applyStimulus(1'b0, 32'h0000_0800, 32'h0);
    applyStimulus(1'b0, 32'h0000_0000, 32'h0);
    applyStimulus(1'b1, 32'h0000_0404, 32'hCAFE_F00D);
    applyStimulus(1'b0, 32'h0000_0000, 32'h0);
    applyStimulus(1'b0, 32'h0000_0800, 32'h0);
    applyStimulus(1'b0, 32'h0000_0404, 32'h0);

    $display("[TB] slow memory");
    ack_delay = 10;
    applyStimulus(1'b0, 32'h0000_0C00, 32'h0);
    applyStimulus(1'b0, 32'h0000_1060, 32'h0);
    checkOutput("slow_stable", stab_err, 0);

    $display("[TB] random accesses");
    for (int r = 0; r < 150; r++) begin
      a = ($urandom_range(0, 7) << 10) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
      ack_delay = $urandom_range(0, 3);
      applyStimulus(1'($urandom_range(0, 1)), a, $urandom);
    end

    $display("[TB] reset during refill");
    ack_delay     = 20;
    p1_addr_i     = 32'h0000_2060;
    p1_MemRead_i  = 1'b1;
    n = 0;
    while (!(mem_enable_o === 1'b1 && mem_write_o === 1'b0) && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    checkOutput("t6_refill_seen", mem_enable_o, 1);
    @(negedge clk_i);
    @(negedge clk_i);
    #2;
    rst_i        = 1'b0;
    p1_MemRead_i = 1'b0;
    #1;
    checkOutput("t6_rst_enable", mem_enable_o, 0);
    checkOutput("t6_rst_miss_cnt", miss_cnt_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    model_reset();
    ack_delay = 1;
    @(negedge clk_i);
    applyStimulus(1'b0, 32'h0000_2060, 32'h0);
    applyStimulus(1'b0, 32'h0000_2060, 32'h0);

    checkOutput("outputs_stable", stab_err, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_2way_param.md
Name: dcache_2way_param

Overview:
Parametrised two-way set-associative, write-back, write-allocate L1 data cache that sits between the CPU MEM stage and the line-wide data memory. It replaces the direct-mapped data cache and adds per-set LRU replacement, configurable line size and set count, and hit/miss performance counters. Tag, valid, dirty, LRU and data storage are internal register arrays; there are no external SRAM instances.

Parameters:
ADDR_W, 32, byte-address width
LINE_BYTES, 32, bytes per line; power of 2, at least 8; LINE_W = 8*LINE_BYTES
SETS, 32, sets per way; power of 2, at least 2
Derived constants:
- OFF_W = log2(LINE_BYTES)
- IDX_W = log2(SETS)
- TAG_W = ADDR_W - IDX_W - OFF_W

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-low reset
p1_addr_i  in  ADDR_W  CPU byte address; word-aligned
p1_data_i  in  32  CPU store data
p1_MemRead_i  in  1  load request
p1_MemWrite_i  in  1  store request; never asserted together with p1_MemRead_i
p1_data_o  out  32  load data
p1_stall_o  out  1  CPU must hold its request while this is high
mem_addr_o  out  ADDR_W  line-aligned memory address (low OFF_W bits are 0)
mem_data_o  out  LINE_W  write-back line
mem_enable_o  out  1  memory request, held until ack
mem_write_o  out  1  1 = write-back, 0 = refill read
mem_data_i  in  LINE_W  refill line, valid when mem_ack_i = 1
mem_ack_i  in  1  one-cycle completion pulse
hit_cnt_o  out  32  completed hit accesses, saturating
miss_cnt_o  out  32  misses, saturating

Behaviour:
- Address split: offset = addr[OFF_W-1:0], index = addr[OFF_W+IDX_W-1:OFF_W], tag = the remaining upper bits. Word select = offset[OFF_W-1:2].
- Reset (async): state=IDLE; all valid, dirty and LRU bits = 0; counters = 0; mem_enable_o = mem_write_o = 0; mem_addr_o = 0. Line data is not reset.
- Hit (combinational): req & valid[w][idx] & tag[w][idx]==tag, for way 0 or way 1. Both ways can never hit at once.
- p1_stall_o = req & ~hit. p1_data_o = selected word of the hit line when there is a read hit, else 0.
- Write hit: on the clock edge, replace only the selected word, set dirty[w][idx] = 1, and increment hit_cnt_o.
- Any hit makes the hit way MRU: LRU[idx] = the other way.
- States:
  - IDLE: if req & ~hit, increment miss_cnt_o and go to MISS.
  - MISS: choose victim = way 0 if it is invalid, else way 1 if it is invalid, else LRU[idx]; latch it. If the victim is valid and dirty, go to WRITEBACK with mem_enable=1, mem_write=1, mem_addr = {victim tag, idx, 0}, mem_data_o = victim line. Otherwise go to REFILL with mem_enable=1, mem_write=0, mem_addr = {tag, idx, 0}.
  - WRITEBACK: hold all memory outputs until mem_ack_i. On ack, switch to the refill request in the same edge and go to REFILL.
  - REFILL: hold until mem_ack_i. On ack: write mem_data_i into the victim way, set valid=1, dirty=0, tag = request tag; clear mem_enable; go to REFILL_DONE.
  - REFILL_DONE: one cycle for the array to settle; go to IDLE. The access then hits, and a store marks the line dirty through the normal hit path.
- Latency: a clean miss with ack one cycle after enable shows stall for 4 cycles. A dirty miss adds the write-back time.
- Memory outputs stay stable while enable is high and not yet acked. mem_ack_i seen in IDLE or REFILL_DONE is ignored.
- If the request is dropped mid-miss, the memory transaction still completes and the line is installed. No hit is counted.
- Counters saturate at 0xFFFFFFFF.
- Reset asserted mid-transaction aborts the transaction immediately; the memory side must tolerate the abandoned request.

Test Plan:
Defaults: index = addr[9:5], tag = addr[31:10].
1. Cold read of 0x0000_0004 with memory returning line L0 (word1 = 0x11111111) -> mem_addr_o = 0x00, mem_write_o = 0, stall for 4 cycles, then p1_data_o = 0x11111111; miss_cnt_o = 1, hit_cnt_o = 1.
2. Write 0xDEADBEEF to 0x0008, then read 0x0008 -> no stall, p1_data_o = 0xDEADBEEF; no memory activity.
3. Lines 0x000 and 0x400 are both resident; touch 0x000; read 0x800 -> way holding 0x400 is evicted (LRU); 0x000 still hits.
4. Dirty victim: write 0x400, touch 0x000, read 0x800 -> write-back at mem_addr_o = 0x400 with mem_write_o = 1 and the modified line, then refill from 0x800.
5. Delay mem_ack_i by 10 cycles -> mem_addr_o, mem_enable_o and mem_data_o stay constant and stall stays high throughout.
6. Assert rst_i low during REFILL -> mem_enable_o = 0 immediately; a subsequent read of the same address misses again.
